// File: rtl/reg_dump_streamer.sv
// reg_dump_streamer
// Snapshots the flat register-file dump bus when start is accepted, then
// streams the snapshot out one register per valid/ready transfer. The sink
// therefore sees one coherent register state, even while the pipeline keeps
// running.
// Optional build macro: REG_DUMP_STREAMER_CSUM_EN adds a trailing word with
// out_idx = NREGS that carries the XOR of all snapshot words.
module reg_dump_streamer #(
  parameter int NREGS = 32,
  parameter int XLEN  = 32,
  parameter int IW    = $clog2(NREGS) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREGS*XLEN-1:0] reg_dump,
  input  logic                  start,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_data,
  output logic [IW-1:0]         out_idx,
  output logic                  out_last,
  output logic                  done
);

  localparam int AW = $clog2(NREGS);

`ifdef REG_DUMP_STREAMER_CSUM_EN
  // The checksum word is the final word of the stream.
  localparam logic [IW-1:0] CSUM_IDX = IW'(NREGS);
  localparam logic [IW-1:0] LAST_IDX = CSUM_IDX;
`else
  localparam logic [IW-1:0] LAST_IDX = IW'(NREGS - 1);
`endif

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_e;

  state_e          state_q, state_d;
  logic            busy_q, busy_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_data_q, out_data_d;
  logic [IW-1:0]   out_idx_q, out_idx_d;
  logic            out_last_q, out_last_d;
  logic            done_q, done_d;
  logic            snap_en;
  logic [IW-1:0]   idx_nxt;
  logic [XLEN-1:0] word_nxt;

  logic [XLEN-1:0] shadow_q [NREGS];

  // Capture the whole dump on the accepting edge; it is only read while streaming.
  // NOTE: the snapshot array carries no reset; every word is written before it is read.
  always_ff @(posedge clk) begin
    if (snap_en) begin
      for (int i = 0; i < NREGS; i++) begin
        shadow_q[i] <= reg_dump[XLEN*i +: XLEN];
      end
    end
  end

`ifdef REG_DUMP_STREAMER_CSUM_EN
  logic [XLEN-1:0] csum;

  // XOR-reduce the snapshot to produce the trailing checksum word.
  always_comb begin
    csum = '0;
    for (int i = 0; i < NREGS; i++) begin
      csum = csum ^ shadow_q[i];
    end
  end

  // Select the word that follows the current one: a register or the checksum.
  always_comb begin
    idx_nxt  = out_idx_q + IW'(1);
    word_nxt = (idx_nxt == CSUM_IDX) ? csum : shadow_q[idx_nxt[AW-1:0]];
  end
`else
  // Select the register that follows the current one.
  always_comb begin
    idx_nxt  = out_idx_q + IW'(1);
    word_nxt = shadow_q[idx_nxt[AW-1:0]];
  end
`endif

  // Next-state and next-output logic. Outputs hold unless a start or transfer changes them.
  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    snap_en     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // Word 0 is loaded straight from the bus; it equals the value being snapshotted.
          snap_en     = 1'b1;
          state_d     = S_SEND;
          busy_d      = 1'b1;
          out_valid_d = 1'b1;
          out_idx_d   = '0;
          out_data_d  = reg_dump[XLEN-1:0];
          out_last_d  = (LAST_IDX == '0);
        end
      end
      S_SEND: begin
        if (out_valid_q && out_ready) begin
          if (out_idx_q == LAST_IDX) begin
            state_d     = S_IDLE;
            busy_d      = 1'b0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
          end else begin
            out_idx_d  = idx_nxt;
            out_data_d = word_nxt;
            out_last_d = (idx_nxt == LAST_IDX);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and registered outputs, with synchronous active-high reset.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign done      = done_q;

endmodule
